// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data-length/parity encodings and helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] DLEN_5 = 2'b00;
    localparam logic [1:0] DLEN_6 = 2'b01;
    localparam logic [1:0] DLEN_7 = 2'b10;
    localparam logic [1:0] DLEN_8 = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic [3:0] data_bits_count(input logic [1:0] cfg);
        case (cfg)
            DLEN_5:  data_bits_count = 4'd5;
            DLEN_6:  data_bits_count = 4'd6;
            DLEN_7:  data_bits_count = 4'd7;
            DLEN_8:  data_bits_count = 4'd8;
            default: data_bits_count = 4'd8;
        endcase
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] cfg);
        case (cfg)
            DLEN_5:  data_mask = 8'h1F;
            DLEN_6:  data_mask = 8'h3F;
            DLEN_7:  data_mask = 8'h7F;
            DLEN_8:  data_mask = 8'hFF;
            default: data_mask = 8'hFF;
        endcase
    endfunction

    // Parity covers only the bits actually sent; bits above the length are ignored.
    function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] cfg,
                                         input logic odd);
        logic p;
        p = ^(data & data_mask(cfg));
        case (odd)
            PAR_EVEN: calc_parity = p;
            PAR_ODD:  calc_parity = ~p;
            default:  calc_parity = p;
        endcase
    endfunction

endpackage

// File: rtl/uart_tick_cnt.sv
// Oversample tick counter: counts enabled ticks modulo OVERSAMPLE, strobes on the last one.
module uart_tick_cnt #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_wrap
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over an enabled tick.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_wrap = i_en && !i_clr && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5-8 data bits, optional parity, 1/2 stop bits).
// Optional clear-to-send flow control is enabled by defining UART_TX_CTS_EN.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tick,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic [1:0] cfg_data_bits,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    input  logic       cfg_two_stop,
`ifdef UART_TX_CTS_EN
    input  logic       cts_n,
`endif
    output logic       o_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  last_bit_q, last_bit_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        par_en_q, par_en_d;
    logic        two_stop_q, two_stop_d;
    logic        parity_q, parity_d;
    logic        txd_q, txd_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        idle_q, idle_d;
    logic        accept_s;
    logic        bit_end_s;
    logic        tick_clr_s;

    assign tick_clr_s = (state_q == ST_IDLE);

    uart_tick_cnt #(
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_W      (CNT_W)
    ) u_tick_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (tick_clr_s),
        .i_en   (i_tick),
        .o_wrap (bit_end_s)
    );

`ifdef UART_TX_CTS_EN
    logic cts_meta_q;
    logic cts_sync_q;

    // Two-flop synchroniser for the asynchronous clear-to-send input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cts_meta_q <= 1'b0;
            cts_sync_q <= 1'b0;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    assign tx_ready = idle_q && !cts_sync_q;
`else
    assign tx_ready = idle_q;
`endif

    assign accept_s = tx_valid && tx_ready;

    // Frame sequencing; o_txd is computed alongside the state so both change on one edge.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        parity_d   = parity_q;
        txd_d      = txd_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (accept_s) begin
                    shift_d    = tx_data;
                    last_bit_d = 3'(data_bits_count(cfg_data_bits) - 4'd1);
                    par_en_d   = cfg_parity_en;
                    two_stop_d = cfg_two_stop;
                    parity_d   = calc_parity(tx_data, cfg_data_bits, cfg_parity_odd);
                    bit_cnt_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    txd_d      = 1'b0;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    txd_d   = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_q == last_bit_q) begin
                        if (par_en_q) begin
                            txd_d   = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_end_s) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        idle_d = (state_d == ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            last_bit_q <= 3'd0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            last_bit_q <= last_bit_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            parity_q   <= parity_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            idle_q     <= idle_d;
        end
    end

    assign o_txd   = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg; the line is sampled once per baud tick while busy.
module tb_uart_tx_cfg;

    logic       clk;
    logic       reset;
    logic       i_tick;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [1:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic       cfg_parity_odd;
    logic       cfg_two_stop;
    logic       o_txd;
    logic       tx_busy;
    logic       tx_done;
`ifdef UART_TX_CTS_EN
    logic       cts_n;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    logic tick_en  = 1'b0;
    logic samp_q[$];

    uart_tx_cfg #(.OVERSAMPLE(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_tick         (i_tick),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_two_stop   (cfg_two_stop),
`ifdef UART_TX_CTS_EN
        .cts_n          (cts_n),
`endif
        .o_txd          (o_txd),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One baud tick every fourth clock.
    initial begin
        int ph;
        ph     = 0;
        i_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph     = (ph + 1) % 4;
            i_tick = tick_en && (ph == 0);
        end
    end

    // Record the line value in force at each tick of a frame, and count done pulses.
    always @(negedge clk) begin
        if (tx_busy && i_tick) samp_q.push_back(o_txd);
        if (tx_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // seq[j] is the expected level of bit slot j; each slot must hold for 16 ticks.
    task automatic check_frame(input string tag, input logic [31:0] seq, input int nslots);
        logic [31:0] w;
        check($sformatf("%s_len", tag), 32'(samp_q.size()), 32'(nslots * 16));
        for (int j = 0; j < nslots; j++) begin
            w = 32'h0;
            for (int s = 0; s < 16; s++) begin
                w[s] = (j * 16 + s < samp_q.size()) ? samp_q[j * 16 + s] : 1'bx;
            end
            check($sformatf("%s_slot%0d", tag, j), w, seq[j] ? 32'h0000FFFF : 32'h0);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1;
        samp_q.delete();
        done_cnt = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] nb, input logic pen,
                        input logic podd, input logic two);
        tx_data        = d;
        cfg_data_bits  = nb;
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_two_stop   = two;
        tx_valid       = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt >= n) break;
        end
        check($sformatf("%s_done_seen", tag), 32'(done_cnt >= n), 32'd1);
    endtask

    task automatic check_idle(input string tag, input int ndone);
        repeat (6) @(posedge clk);
        #2;
        check($sformatf("%s_done_cnt", tag), 32'(done_cnt), 32'(ndone));
        check($sformatf("%s_ready", tag), 32'(tx_ready), 32'd1);
        check($sformatf("%s_busy", tag), 32'(tx_busy), 32'd0);
        check($sformatf("%s_txd", tag), 32'(o_txd), 32'd1);
    endtask

    initial begin
        reset          = 1'b0;
        tx_valid       = 1'b0;
        tx_data        = 8'h00;
        cfg_data_bits  = 2'b11;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_two_stop   = 1'b0;
`ifdef UART_TX_CTS_EN
        cts_n          = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        tick_en = 1'b1;
        repeat (10) @(posedge clk);

        // Reset mid-idle with random inputs.
        #3;
        reset          = 1'b0;
        tx_valid       = 1'($urandom_range(1));
        tx_data        = 8'($urandom);
        cfg_data_bits  = 2'($urandom);
        cfg_parity_en  = 1'($urandom_range(1));
        cfg_parity_odd = 1'($urandom_range(1));
        cfg_two_stop   = 1'($urandom_range(1));
        repeat (4) @(posedge clk);
        #2;
        check("rst_txd", 32'(o_txd), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        clear_mon();
        send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
        wait_done("a5", 1);
        check_idle("a5", 1);
        check_frame("a5", 32'b1101001010, 10);

        // 7E2 0xB5, inputs scrambled mid-frame: 0,1,0,1,0,1,1,0,p0,1,1
        clear_mon();
        send(8'hB5, 2'b10, 1'b1, 1'b0, 1'b1);
        repeat (100) @(posedge clk);
        #1;
        tx_data        = 8'h00;
        cfg_data_bits  = 2'b00;
        cfg_parity_odd = 1'b1;
        cfg_two_stop   = 1'b0;
        wait_done("b5", 1);
        check_idle("b5", 1);
        check_frame("b5", 32'b11001101010, 11);

        // 5O1 0x1F: 0,1,1,1,1,1,p0,1
        clear_mon();
        send(8'h1F, 2'b00, 1'b1, 1'b1, 1'b0);
        wait_done("5o1", 1);
        check_idle("5o1", 1);
        check_frame("5o1", 32'b10111110, 8);

        // 6O1 0x00: 0,0,0,0,0,0,0,p1,1
        clear_mon();
        send(8'h00, 2'b01, 1'b1, 1'b1, 1'b0);
        wait_done("6o1", 1);
        check_idle("6o1", 1);
        check_frame("6o1", 32'b110000000, 9);

        // Back-to-back 8N1 0x55 then 0x0F with tx_valid held.
        clear_mon();
        tx_data        = 8'h55;
        cfg_data_bits  = 2'b11;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_two_stop   = 1'b0;
        tx_valid       = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'h0F;
        wait_done("b2b_first", 1);
        tx_valid = 1'b0;
        check("b2b_second_busy", 32'(tx_busy), 32'd1);
        wait_done("b2b_second", 2);
        check_idle("b2b", 2);
        check_frame("b2b", {12'h0, 10'b1000011110, 10'b1010101010}, 20);

        // Reset during data bit 3 of 0xA5 (bit 3 is 0).
        clear_mon();
        send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #2;
            if (samp_q.size() >= 72) break;
        end
        check("midrst_bit3_txd", 32'(o_txd), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_txd", 32'(o_txd), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 8N1 0x3C after reset: 0,0,0,1,1,1,1,0,0,1
        clear_mon();
        send(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
        wait_done("3c", 1);
        check_idle("3c", 1);
        check_frame("3c", 32'b1001111000, 10);

`ifdef UART_TX_CTS_EN
        // Clear-to-send withheld blocks acceptance; withdrawn mid-frame the frame completes.
        clear_mon();
        cts_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tx_data       = 8'h55;
        cfg_data_bits = 2'b11;
        cfg_parity_en = 1'b0;
        cfg_two_stop  = 1'b0;
        tx_valid      = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check("cts_ready", 32'(tx_ready), 32'd0);
        check("cts_txd", 32'(o_txd), 32'd1);
        check("cts_busy", 32'(tx_busy), 32'd0);
        cts_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (tx_busy) break;
        end
        tx_valid = 1'b0;
        check("cts_started", 32'(tx_busy), 32'd1);
        repeat (50) @(posedge clk);
        #1;
        cts_n = 1'b1;
        wait_done("cts", 1);
        repeat (6) @(posedge clk);
        #2;
        check("cts_done_cnt", 32'(done_cnt), 32'd1);
        check_frame("cts", 32'b1010101010, 10);
        cts_n = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
